// File: rtl/adc_responder_if.sv
// rtl/adc_responder_if.sv - serial ADC bus between a master and the responder
interface adc_responder_if;
    logic ADC_SCLK;
    logic CS_N;
    logic ADC_SADDR;
    logic ADC_SDAT;
    logic sdat_oe;

    modport master (
        output ADC_SCLK,
        output CS_N,
        output ADC_SADDR,
        input  ADC_SDAT,
        input  sdat_oe
    );

    modport slave (
        input  ADC_SCLK,
        input  CS_N,
        input  ADC_SADDR,
        output ADC_SDAT,
        output sdat_oe
    );
endinterface

// File: rtl/adc_responder.sv
// rtl/adc_responder.sv - oversampled serial ADC slave returning 12-bit channel samples
module adc_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    adc_responder_if.slave      adc,
    input  logic [95:0]         chan_data,
    output logic [2:0]          cur_ch,
    output logic [2:0]          addr_rx,
    output logic                frame_done
);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] saddr_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   saddr_q;
    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic                   cs_rise_q;
    logic                   cs_fall_q;
    logic                   seen_q;
    logic                   armed_q;

    logic sclk_s;
    logic cs_s;
    logic saddr_s;

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s    = cs_sync_q[SYNC_STAGES-1];
    assign saddr_s = saddr_sync_q[SYNC_STAGES-1];

    // Edge pulses are registered once more so every action lands SYNC_STAGES+2 clocks after the raw edge.
    // armed_q blocks the false CS_N fall seen while the reset-high synchronizer drains into a low CS_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= '0;
            cs_sync_q    <= '1;
            saddr_sync_q <= '0;
            sclk_prev_q  <= 1'b0;
            cs_prev_q    <= 1'b1;
            saddr_q      <= 1'b0;
            sclk_rise_q  <= 1'b0;
            sclk_fall_q  <= 1'b0;
            cs_rise_q    <= 1'b0;
            cs_fall_q    <= 1'b0;
            seen_q       <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], adc.ADC_SCLK};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], adc.CS_N};
            saddr_sync_q <= {saddr_sync_q[SYNC_STAGES-2:0], adc.ADC_SADDR};
            sclk_prev_q  <= sclk_s;
            cs_prev_q    <= cs_s;
            saddr_q      <= saddr_s;
            sclk_rise_q  <= sclk_s & ~sclk_prev_q;
            sclk_fall_q  <= ~sclk_s & sclk_prev_q;
            cs_rise_q    <= cs_s & ~cs_prev_q;
            cs_fall_q    <= ~cs_s & cs_prev_q;
            seen_q       <= 1'b1;
            armed_q      <= armed_q | (seen_q & cs_sync_q[0]);
        end
    end

    state_t      state_q, state_d;
    logic [3:0]  rise_cnt_q, rise_cnt_d;
    logic [3:0]  fall_cnt_q, fall_cnt_d;
    logic [14:0] shift_q, shift_d;
    logic        sdat_q, sdat_d;
    logic [2:0]  addr_cap_q, addr_cap_d;
    logic [2:0]  addr_rx_q, addr_rx_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        frame_done_q, frame_done_d;

    logic [6:0]  sample_base;
    logic [11:0] sample;

    always_comb begin
        sample_base = 7'(cur_ch_q) * 7'd12;
        sample      = chan_data[sample_base +: 12];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rise_cnt_q   <= 4'd0;
            fall_cnt_q   <= 4'd0;
            shift_q      <= '0;
            sdat_q       <= 1'b0;
            addr_cap_q   <= 3'd0;
            addr_rx_q    <= 3'd0;
            cur_ch_q     <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rise_cnt_q   <= rise_cnt_d;
            fall_cnt_q   <= fall_cnt_d;
            shift_q      <= shift_d;
            sdat_q       <= sdat_d;
            addr_cap_q   <= addr_cap_d;
            addr_rx_q    <= addr_rx_d;
            cur_ch_q     <= cur_ch_d;
            frame_done_q <= frame_done_d;
        end
    end

    // The word's MSB is always 0 at load, so only the lower 15 bits are stored and sdat_q carries the MSB.
    always_comb begin
        state_d      = state_q;
        rise_cnt_d   = rise_cnt_q;
        fall_cnt_d   = fall_cnt_q;
        shift_d      = shift_q;
        sdat_d       = sdat_q;
        addr_cap_d   = addr_cap_q;
        addr_rx_d    = addr_rx_q;
        cur_ch_d     = cur_ch_q;
        frame_done_d = 1'b0;

        if (cs_rise_q) begin
            state_d    = ST_IDLE;
            rise_cnt_d = 4'd0;
            fall_cnt_d = 4'd0;
            cur_ch_d   = 3'd0;
            sdat_d     = 1'b0;
        end else if (cs_fall_q && armed_q) begin
            state_d    = ST_ACTIVE;
            shift_d    = {3'b000, sample};
            rise_cnt_d = 4'd0;
            fall_cnt_d = 4'd0;
            sdat_d     = 1'b0;
        end else if (state_q == ST_ACTIVE) begin
            if (sclk_fall_q) begin
                if (fall_cnt_q == 4'd15) begin
                    shift_d    = {3'b000, sample};
                    sdat_d     = 1'b0;
                    fall_cnt_d = 4'd0;
                end else begin
                    sdat_d     = shift_q[14];
                    shift_d    = {shift_q[13:0], 1'b0};
                    fall_cnt_d = fall_cnt_q + 4'd1;
                end
            end
            if (sclk_rise_q) begin
                case (rise_cnt_q)
                    4'd2:    addr_cap_d[2] = saddr_q;
                    4'd3:    addr_cap_d[1] = saddr_q;
                    4'd4:    addr_cap_d[0] = saddr_q;
                    default: ;
                endcase
                if (rise_cnt_q == 4'd15) begin
                    addr_rx_d    = addr_cap_q;
                    cur_ch_d     = addr_cap_q;
                    frame_done_d = 1'b1;
                    rise_cnt_d   = 4'd0;
                end else begin
                    rise_cnt_d = rise_cnt_q + 4'd1;
                end
            end
        end
    end

    assign adc.ADC_SDAT = sdat_q;
    assign adc.sdat_oe  = (state_q == ST_ACTIVE);
    assign cur_ch       = cur_ch_q;
    assign addr_rx      = addr_rx_q;
    assign frame_done   = frame_done_q;

endmodule
